// File: rtl/uart_rx_oversample_if.sv
// rtl/uart_rx_oversample_if.sv - receiver-to-rfifo write port and per-character status pulses
interface uart_rx_oversample_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d_out;
    logic             fifo_we_en;
    logic             fifo_full;
    logic             frame_err;
    logic             parity_err;
    logic             overrun;

    modport master (
        output d_out,
        output fifo_we_en,
        output frame_err,
        output parity_err,
        output overrun,
        input  fifo_full
    );

    modport slave (
        input  d_out,
        input  fifo_we_en,
        input  frame_err,
        input  parity_err,
        input  overrun,
        output fifo_full
    );
endinterface

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling UART receiver feeding rfifo
module uart_rx_oversample #(
    parameter int WIDTH      = 8,
    parameter int OSR        = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  baud_tick,
    input  logic                  rx_data,
    output logic                  rx_busy,
    uart_rx_oversample_if.master  fifo
);
    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(WIDTH);
    localparam logic [TW-1:0] HALF_M1  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] OSR_M1   = TW'(OSR - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta, rxs;
    logic [TW-1:0]    tick_q, tick_d;
    logic [BW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             we_q, we_d;
    logic             fe_q, fe_d;
    logic             pe_q, pe_d;
    logic             ov_q, ov_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            we_q    <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            rx_meta <= rx_data;
            rxs     <= rx_meta;
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            we_q    <= we_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        dout_d  = dout_q;
        we_d    = 1'b0;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        ov_d    = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d = START;
                        tick_d  = '0;
                    end
                end
                START: begin
                    if (tick_q == HALF_M1) begin
                        tick_d  = '0;
                        idx_d   = '0;
                        state_d = rxs ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == OSR_M1) begin
                        tick_d  = '0;
                        shift_d = {rxs, shift_q[WIDTH-1:1]};
                        if (idx_q == LAST_BIT) begin
                            idx_d   = '0;
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_q == OSR_M1) begin
                        tick_d  = '0;
                        par_d   = ((^shift_q) ^ rxs) != ODD;
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    // IDLE is re-entered at mid stop so a back-to-back start edge is not missed
                    if (tick_q == OSR_M1) begin
                        tick_d = '0;
                        if (rxs) begin
                            state_d = IDLE;
                            if (!fifo.fifo_full) begin
                                dout_d = shift_q;
                                we_d   = 1'b1;
                                pe_d   = par_q;
                            end else begin
                                ov_d = 1'b1;
                            end
                        end else begin
                            fe_d    = 1'b1;
                            state_d = BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_busy         = (state_q != IDLE);
    assign fifo.d_out      = dout_q;
    assign fifo.fifo_we_en = we_q;
    assign fifo.frame_err  = fe_q;
    assign fifo.parity_err = pe_q;
    assign fifo.overrun    = ov_q;
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - randomized self-checking bench for uart_rx_oversample
module tb_uart_rx_oversample;
    localparam int BIT_CLK = 64;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic baud_tick = 1'b0;
    logic rx_a = 1'b1;
    logic rx_b = 1'b1;
    logic busy_a, busy_b;

    uart_rx_oversample_if #(.WIDTH(8)) if_a ();
    uart_rx_oversample_if #(.WIDTH(8)) if_b ();

    uart_rx_oversample #(.WIDTH(8), .OSR(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .rx_data(rx_a),
        .rx_busy(busy_a), .fifo(if_a.master)
    );

    uart_rx_oversample #(.WIDTH(8), .OSR(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
        .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .rx_data(rx_b),
        .rx_busy(busy_b), .fifo(if_b.master)
    );

    int checks = 0;
    int failures = 0;

    int we_a = 0, fe_a = 0, ov_a = 0, pe_a = 0, multi_a = 0;
    int we_b = 0, fe_b = 0, ov_b = 0, pe_b = 0;
    logic [7:0] q_a[$];
    logic [8:0] q_b[$];
    logic [7:0] last_a = 8'h00;

    always #5 clk = ~clk;

    initial begin
        int tcnt;
        tcnt = 0;
        forever begin
            @(negedge clk);
            baud_tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (if_a.fifo_we_en) begin we_a++; q_a.push_back(if_a.d_out); end
        if (if_a.frame_err) fe_a++;
        if (if_a.overrun) ov_a++;
        if (if_a.parity_err) pe_a++;
        if ((int'(if_a.fifo_we_en) + int'(if_a.frame_err) + int'(if_a.overrun)) > 1) multi_a++;
        if (if_b.fifo_we_en) begin we_b++; q_b.push_back({if_b.parity_err, if_b.d_out}); end
        if (if_b.frame_err) fe_b++;
        if (if_b.overrun) ov_b++;
        if (if_b.parity_err) pe_b++;
    end

    task automatic drive_line(input bit sel, input logic v, input int nclk);
        if (sel) rx_b = v; else rx_a = v;
        repeat (nclk) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par,
                              input logic pbit, input logic stop);
        drive_line(sel, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_line(sel, d[i], BIT_CLK);
        if (par) drive_line(sel, pbit, BIT_CLK);
        drive_line(sel, stop, BIT_CLK);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({if_a.d_out, if_a.fifo_we_en, if_a.frame_err, if_a.parity_err, if_a.overrun, busy_a} !== 13'd0) begin
            failures++;
            $display("FAIL reset_a: got %h want 0", {if_a.d_out, if_a.fifo_we_en, if_a.frame_err, if_a.parity_err, if_a.overrun, busy_a});
        end
        checks++;
        if ({if_b.d_out, if_b.fifo_we_en, if_b.frame_err, if_b.parity_err, if_b.overrun, busy_b} !== 13'd0) begin
            failures++;
            $display("FAIL reset_b: got %h want 0", {if_b.d_out, if_b.fifo_we_en, if_b.frame_err, if_b.parity_err, if_b.overrun, busy_b});
        end
        rstn = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
    endtask

    task automatic test_basic(input logic [7:0] d, input string name);
        int w0, e0, n0;
        w0 = we_a; e0 = fe_a + ov_a + pe_a; n0 = q_a.size();
        send_frame(1'b0, d, 1'b0, 1'b0, 1'b1);
        drive_line(1'b0, 1'b1, BIT_CLK);
        last_a = d;
        checks++;
        if (we_a - w0 !== 1) begin
            failures++; $display("FAIL %s strobes: got %0d want 1", name, we_a - w0);
        end else begin
            checks++;
            if (q_a[n0] !== d) begin
                failures++; $display("FAIL %s data: got %h want %h", name, q_a[n0], d);
            end
        end
        checks++;
        if ((fe_a + ov_a + pe_a) - e0 !== 0) begin
            failures++; $display("FAIL %s errors: got %0d want 0", name, (fe_a + ov_a + pe_a) - e0);
        end
        checks++;
        if (if_a.d_out !== d || busy_a !== 1'b0) begin
            failures++; $display("FAIL %s hold: d_out %h busy %b want %h 0", name, if_a.d_out, busy_a, d);
        end
    endtask

    task automatic test_false_start;
        int w0, e0;
        w0 = we_a; e0 = fe_a + ov_a + pe_a;
        drive_line(1'b0, 1'b0, 16);
        drive_line(1'b0, 1'b1, 2 * BIT_CLK);
        checks++;
        if (we_a - w0 !== 0 || (fe_a + ov_a + pe_a) - e0 !== 0 || busy_a !== 1'b0) begin
            failures++;
            $display("FAIL false_start: strobes %0d errors %0d busy %b want 0 0 0", we_a - w0, (fe_a + ov_a + pe_a) - e0, busy_a);
        end
        test_basic(8'h3C, "after_false_start");
    endtask

    task automatic test_frame_err;
        int w0, f0;
        w0 = we_a; f0 = fe_a;
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
        drive_line(1'b0, 1'b0, 2 * BIT_CLK);
        drive_line(1'b0, 1'b1, BIT_CLK);
        checks++;
        if (fe_a - f0 !== 1 || we_a - w0 !== 0) begin
            failures++; $display("FAIL frame_err: fe %0d we %0d want 1 0", fe_a - f0, we_a - w0);
        end
        checks++;
        if (if_a.d_out !== last_a || busy_a !== 1'b0) begin
            failures++; $display("FAIL frame_err_hold: d_out %h busy %b want %h 0", if_a.d_out, busy_a, last_a);
        end
        test_basic(8'h81, "after_break");
    endtask

    task automatic test_overrun;
        int w0, o0;
        w0 = we_a; o0 = ov_a;
        if_a.fifo_full = 1'b1;
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        drive_line(1'b0, 1'b1, BIT_CLK);
        if_a.fifo_full = 1'b0;
        checks++;
        if (ov_a - o0 !== 1 || we_a - w0 !== 0) begin
            failures++; $display("FAIL overrun: ov %0d we %0d want 1 0", ov_a - o0, we_a - w0);
        end
        checks++;
        if (if_a.d_out !== last_a) begin
            failures++; $display("FAIL overrun_hold: d_out %h want %h", if_a.d_out, last_a);
        end
        test_basic(8'h12, "after_overrun");
    endtask

    task automatic test_parity;
        logic [7:0] d[$];
        logic       p[$];
        int         n0;
        n0 = q_b.size();
        d.push_back(8'h07); p.push_back(1'b1);
        d.push_back(8'h07); p.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            d.push_back(8'($urandom)); p.push_back(1'($urandom));
        end
        foreach (d[i]) begin
            send_frame(1'b1, d[i], 1'b1, p[i], 1'b1);
            drive_line(1'b1, 1'b1, $urandom_range(0, 1) * BIT_CLK);
        end
        drive_line(1'b1, 1'b1, BIT_CLK);
        checks++;
        if (q_b.size() - n0 !== d.size()) begin
            failures++; $display("FAIL parity_count: got %0d want %0d", q_b.size() - n0, d.size());
        end else begin
            foreach (d[i]) begin
                logic [8:0] want;
                want = {1'(($countones(d[i]) + int'(p[i])) % 2), d[i]};
                checks++;
                if (q_b[n0 + i] !== want) begin
                    failures++; $display("FAIL parity_frame%0d: got {pe,data}=%h want %h", i, q_b[n0 + i], want);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] exp_q[$];
        int n0, o0, f0, exp_ov, exp_fe;
        n0 = q_a.size(); o0 = ov_a; f0 = fe_a;
        exp_ov = 0; exp_fe = 0;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] d;
            bit full, bad;
            d = 8'($urandom);
            full = ($urandom_range(0, 3) == 0);
            bad = ($urandom_range(0, 4) == 0);
            if_a.fifo_full = full;
            send_frame(1'b0, d, 1'b0, 1'b0, !bad);
            if (bad) begin
                exp_fe++;
                drive_line(1'b0, 1'b0, BIT_CLK);
                drive_line(1'b0, 1'b1, BIT_CLK);
            end else begin
                if (full) exp_ov++;
                else begin exp_q.push_back(d); last_a = d; end
                drive_line(1'b0, 1'b1, $urandom_range(0, 2) * BIT_CLK);
            end
        end
        if_a.fifo_full = 1'b0;
        drive_line(1'b0, 1'b1, BIT_CLK);
        checks++;
        if (ov_a - o0 !== exp_ov || fe_a - f0 !== exp_fe) begin
            failures++; $display("FAIL random_errs: ov %0d fe %0d want %0d %0d", ov_a - o0, fe_a - f0, exp_ov, exp_fe);
        end
        checks++;
        if (q_a.size() - n0 !== exp_q.size()) begin
            failures++; $display("FAIL random_count: got %0d want %0d", q_a.size() - n0, exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (q_a[n0 + i] !== exp_q[i]) begin
                    failures++; $display("FAIL random_data%0d: got %h want %h", i, q_a[n0 + i], exp_q[i]);
                end
            end
        end
        checks++;
        if (multi_a !== 0) begin
            failures++; $display("FAIL exclusive_pulses: got %0d overlapping cycles want 0", multi_a);
        end
        checks++;
        if (if_a.d_out !== last_a) begin
            failures++; $display("FAIL random_last: d_out %h want %h", if_a.d_out, last_a);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        int w0, e0;
        d = 8'hC3;
        w0 = we_a; e0 = fe_a + ov_a + pe_a;
        drive_line(1'b0, 1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_line(1'b0, d[i], BIT_CLK);
        drive_line(1'b0, d[4], BIT_CLK / 2);
        rx_a = 1'b1;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        checks++;
        if ({if_a.d_out, if_a.fifo_we_en, if_a.frame_err, if_a.parity_err, if_a.overrun, busy_a} !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid: got %h want 0", {if_a.d_out, if_a.fifo_we_en, if_a.frame_err, if_a.parity_err, if_a.overrun, busy_a});
        end
        drive_line(1'b0, 1'b1, 3 * BIT_CLK);
        checks++;
        if (we_a - w0 !== 0 || (fe_a + ov_a + pe_a) - e0 !== 0) begin
            failures++; $display("FAIL reset_mid_quiet: we %0d errs %0d want 0 0", we_a - w0, (fe_a + ov_a + pe_a) - e0);
        end
        test_basic(8'h5A, "after_reset");
    endtask

    initial begin
        if_a.fifo_full = 1'b0;
        if_b.fifo_full = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic(8'hA5, "basic_a5");
        test_false_start;
        test_frame_err;
        test_overrun;
        test_parity;
        test_random;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
